// File: rtl/adc_uart_pkg.sv
// Shared types and constants for the ADC-to-UART framer.
// FRAMER_SEQ_EN adds a sequence-number state to the frame FSM.
package adc_uart_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t DEF_HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
`ifdef FRAMER_SEQ_EN
    ST_SEQ  = 3'd2,
`endif
    ST_DATA = 3'd3,
    ST_SUM  = 3'd4,
    ST_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push when full and pop when
// empty are ignored, so callers may assert them unconditionally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity,
  // and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/adc_uart_framer.sv
// Buffers ADC samples and streams header/samples/checksum frames into a UART
// TX using its start/done handshake. FRAMER_SEQ_EN inserts a sequence byte.
module adc_uart_framer
  import adc_uart_pkg::*;
#(
  parameter int    DATA_W            = 8,
  parameter int    FIFO_DEPTH        = 16,
  parameter int    SAMPLES_PER_FRAME = 4,
  parameter byte_t HEADER_BYTE       = DEF_HEADER_BYTE
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [DATA_W-1:0]           Sample_Data,
  input  logic                        Sample_Valid,
  output logic [DATA_W-1:0]           Tx_Data,
  output logic                        Tx_Start,
  input  logic                        Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Level,
  output logic                        Overflow,
  output logic [7:0]                  Frame_Count
);

  localparam int                LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]  N_LVL = LVL_W'(SAMPLES_PER_FRAME);

  state_e              state_q, state_d, ret_q, ret_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  byte_t               csum_q, csum_d;
  logic [LVL_W-1:0]    idx_q, idx_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                overflow_q, done_q;

  logic [DATA_W-1:0]   fifo_rd;
  logic [LVL_W-1:0]    fifo_level;
  logic                fifo_full, fifo_empty, fifo_pop, done_rise;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .push_i    (Sample_Valid),
    .pop_i     (fifo_pop),
    .wr_data_i (Sample_Data),
    .rd_data_o (fifo_rd),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign done_rise = Tx_Done & ~done_q;
  assign fifo_pop  = (state_q == ST_DATA) & ~fifo_empty;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    csum_d      = csum_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        csum_d = '0;
        idx_d  = '0;
        if (fifo_level >= N_LVL) state_d = ST_HDR;
      end
      ST_HDR: begin
        tx_data_d  = HEADER_BYTE;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
`ifdef FRAMER_SEQ_EN
        ret_d      = ST_SEQ;
`else
        ret_d      = ST_DATA;
`endif
      end
`ifdef FRAMER_SEQ_EN
      ST_SEQ: begin
        tx_data_d  = frame_cnt_q;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
        ret_d      = ST_DATA;
      end
`endif
      ST_DATA: begin
        tx_data_d  = fifo_rd;
        tx_start_d = 1'b1;
        csum_d     = csum_q + fifo_rd;
        idx_d      = idx_q + 1'b1;
        state_d    = ST_WAIT;
        ret_d      = (idx_d < N_LVL) ? ST_DATA : ST_SUM;
      end
      ST_SUM: begin
        tx_data_d  = csum_q;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
        ret_d      = ST_IDLE;
      end
      ST_WAIT: begin
        if (done_rise) begin
          state_d = ret_q;
          if (ret_q == ST_IDLE) frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      csum_q      <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_q | (Sample_Valid & fifo_full);
      done_q      <= Tx_Done;
    end
  end

  assign Tx_Data     = tx_data_q;
  assign Tx_Start    = tx_start_q;
  assign Fifo_Level  = fifo_level;
  assign Overflow    = overflow_q;
  assign Frame_Count = frame_cnt_q;

endmodule

// File: tb/tb_adc_uart_framer.sv
// Scoreboard bench for adc_uart_framer: expected frame bytes are queued when
// samples are driven and compared at each Tx_Start; a small UART model answers.
module tb_adc_uart_framer;
  import adc_uart_pkg::*;

`ifdef FRAMER_SEQ_EN
  localparam int FRAME_BYTES = 7;
`else
  localparam int FRAME_BYTES = 6;
`endif

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Sample_Data = '0;
  logic       Sample_Valid = 1'b0;
  logic [7:0] Tx_Data;
  logic       Tx_Start;
  logic       Tx_Done;
  logic [4:0] Fifo_Level;
  logic       Overflow;
  logic [7:0] Frame_Count;

  logic tx_done_m = 1'b0;
  logic tx_done_force = 1'b0;
  assign Tx_Done = tx_done_m | tx_done_force;

  always #5 clk = ~clk;

  adc_uart_framer dut (
    .Clk          (clk),
    .Reset        (Reset),
    .Sample_Data  (Sample_Data),
    .Sample_Valid (Sample_Valid),
    .Tx_Data      (Tx_Data),
    .Tx_Start     (Tx_Start),
    .Tx_Done      (Tx_Done),
    .Fifo_Level   (Fifo_Level),
    .Overflow     (Overflow),
    .Frame_Count  (Frame_Count)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  byte_t exp_q[$];
  int    frames_queued = 0;
  int    start_cnt = 0;
  int    rise_cnt  = 0;
  bit    mon_waiting = 1'b0;
  bit    stall = 1'b0;
  int    done_hold = 2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // UART model: Tx_Done rises 10 cycles after Tx_Start, only from a low level.
  initial begin : uart_model
    int cnt  = 0;
    int hold = 0;
    forever begin
      bit raise;
      @(posedge clk);
      #1;
      raise = 1'b0;
      if (Reset) begin
        cnt = 0; hold = 0; tx_done_m = 1'b0;
      end else begin
        if (!stall && cnt > 0) begin
          if (cnt > 1) cnt--;
          else if (!tx_done_m) raise = 1'b1;
        end
        if (hold > 0) begin
          hold--;
          if (hold == 0) tx_done_m = 1'b0;
        end
        if (raise) begin
          tx_done_m = 1'b1; hold = done_hold; cnt = 0;
        end
        if (Tx_Start) cnt = 10;
      end
    end
  end

  initial begin : monitor
    bit    prev_start = 1'b0;
    bit    prev_done  = 1'b0;
    byte_t held = '0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        mon_waiting = 1'b0; prev_start = 1'b0; prev_done = Tx_Done;
      end else begin
        if (Tx_Done && !prev_done && mon_waiting) begin
          mon_waiting = 1'b0;
          rise_cnt++;
        end
        if (Tx_Start) begin
          check("start_gap", 32'(prev_start), 32'd0);
          if (exp_q.size() == 0) check("unexpected_start", 32'(Tx_Data), 32'hFFFF);
          else check("tx_byte", 32'(Tx_Data), 32'(exp_q.pop_front()));
          held = Tx_Data;
          mon_waiting = 1'b1;
          start_cnt++;
        end else if (mon_waiting) begin
          check("tx_hold", 32'(Tx_Data), 32'(held));
        end
        prev_start = Tx_Start;
        prev_done  = Tx_Done;
      end
    end
  end

  task automatic queue_frame(input byte_t s0, input byte_t s1, input byte_t s2, input byte_t s3);
    exp_q.push_back(8'hA5);
`ifdef FRAMER_SEQ_EN
    exp_q.push_back(8'(frames_queued));
`endif
    exp_q.push_back(s0); exp_q.push_back(s1);
    exp_q.push_back(s2); exp_q.push_back(s3);
    exp_q.push_back(8'(s0 + s1 + s2 + s3));
    frames_queued++;
  endtask

  task automatic push(input byte_t v);
    Sample_Valid = 1'b1;
    Sample_Data  = v;
    @(negedge clk);
    Sample_Valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    exp_q.delete();
    frames_queued = 0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && !mon_waiting) break;
      @(negedge clk);
    end
    if (i == 4000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input int target);
    int i;
    for (i = 0; i < 500; i++) begin
      if (start_cnt >= target) break;
      @(negedge clk);
    end
    if (i == 500) check("start_timeout", 32'(start_cnt), 32'(target));
  endtask

  task automatic wait_room();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (Fifo_Level <= 5'd12) break;
      @(negedge clk);
    end
    if (i == 2000) check("room_timeout", 32'(Fifo_Level), 32'd12);
  endtask

  initial begin
    int base_s, base_r;

    // Reset values and a basic frame.
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(Tx_Start), 32'd0);
    check("rst_tx_data", 32'(Tx_Data), 32'd0);
    check("rst_level", 32'(Fifo_Level), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    check("rst_frame_cnt", 32'(Frame_Count), 32'd0);
    Reset = 1'b0;
    queue_frame(8'h01, 8'h02, 8'h03, 8'h04);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_drain();
    check("t1_frame_cnt", 32'(Frame_Count), 32'd1);
    check("t1_overflow", 32'(Overflow), 32'd0);
    check("t1_level", 32'(Fifo_Level), 32'd0);

    // Checksum wrap and nine back-to-back frames with incrementing samples.
    do_reset();
    queue_frame(8'hFF, 8'hFF, 8'hFF, 8'h02);
    push(8'hFF); push(8'hFF); push(8'hFF); push(8'h02);
    for (int f = 1; f < 9; f++) begin
      wait_room();
      queue_frame(8'(4*f), 8'(4*f+1), 8'(4*f+2), 8'(4*f+3));
      for (int k = 0; k < 4; k++) push(8'(4*f+k));
    end
    wait_drain();
    check("t2_frame_cnt", 32'(Frame_Count), 32'd9);
    check("t2_overflow", 32'(Overflow), 32'd0);

    // Stalled UART: 21 strobes, the last five are dropped.
    do_reset();
    stall = 1'b1;
    for (int f = 0; f < 4; f++)
      queue_frame(8'(8'h10+4*f), 8'(8'h11+4*f), 8'(8'h12+4*f), 8'(8'h13+4*f));
    for (int i = 0; i < 21; i++) push(8'(8'h10 + i));
    check("t3_level_full", 32'(Fifo_Level), 32'd16);
    check("t3_overflow_set", 32'(Overflow), 32'd1);
    stall = 1'b0;
    wait_drain();
    check("t3_overflow_sticky", 32'(Overflow), 32'd1);
    check("t3_level_drained", 32'(Fifo_Level), 32'd0);
    check("t3_frame_cnt", 32'(Frame_Count), 32'd4);

    // Simultaneous push and pop at level 5.
    do_reset();
    stall = 1'b1;
    base_s = start_cnt;
    queue_frame(8'h30, 8'h31, 8'h32, 8'h33);
    push(8'h30); push(8'h31); push(8'h32); push(8'h33);
    wait_starts(base_s + 1);
    push(8'h34);
    check("t4_level_pre", 32'(Fifo_Level), 32'd5);
    tx_done_force = 1'b1;
    @(negedge clk);
    push(8'h35);
    check("t4_level_pushpop", 32'(Fifo_Level), 32'd5);
    tx_done_force = 1'b0;
    stall = 1'b0;
    queue_frame(8'h34, 8'h35, 8'h36, 8'h37);
    push(8'h36); push(8'h37);
    wait_drain();
    check("t4_frame_cnt", 32'(Frame_Count), 32'd2);

    // Reset in WAIT after the second sample byte aborts the frame.
    do_reset();
    base_s = start_cnt;
    queue_frame(8'h41, 8'h42, 8'h43, 8'h44);
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
`ifdef FRAMER_SEQ_EN
    wait_starts(base_s + 4);
`else
    wait_starts(base_s + 3);
`endif
    Reset = 1'b1;
    @(negedge clk);
    check("t5_tx_start", 32'(Tx_Start), 32'd0);
    check("t5_tx_data", 32'(Tx_Data), 32'd0);
    check("t5_level", 32'(Fifo_Level), 32'd0);
    check("t5_overflow", 32'(Overflow), 32'd0);
    check("t5_frame_cnt", 32'(Frame_Count), 32'd0);
    Reset = 1'b0;
    exp_q.delete();
    frames_queued = 0;
    base_s = start_cnt;
    repeat (30) @(negedge clk);
    check("t5_no_start", 32'(start_cnt), 32'(base_s));
    queue_frame(8'h51, 8'h52, 8'h53, 8'h54);
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    wait_drain();
    check("t5_frame_cnt_after", 32'(Frame_Count), 32'd1);

    // Level-style Tx_Done held 20 cycles, then a spurious pulse in IDLE.
    do_reset();
    done_hold = 20;
    base_s = start_cnt;
    base_r = rise_cnt;
    queue_frame(8'h61, 8'h62, 8'h63, 8'h64);
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    wait_drain();
    check("t6_starts", 32'(start_cnt - base_s), 32'(FRAME_BYTES));
    check("t6_rises", 32'(rise_cnt - base_r), 32'(FRAME_BYTES));
    check("t6_frame_cnt", 32'(Frame_Count), 32'd1);
    repeat (25) @(negedge clk);
    base_s = start_cnt;
    tx_done_force = 1'b1;
    repeat (2) @(negedge clk);
    tx_done_force = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_spurious_start", 32'(start_cnt), 32'(base_s));
    check("t6_spurious_cnt", 32'(Frame_Count), 32'd1);
    done_hold = 2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
